embed_edge_pio: RTL and testbench

EMBED_EDGE_PIO -- requirements
Module: embed_edge_pio

---
 rtl/embed_edge_pio.sv | 104 ++++++++++
 tb/tb_embed_edge_pio.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/embed_edge_pio.sv
// embed_edge_pio: parallel input port with per-bit rise/fall capture, W1C status and irq.
// Define EMBED_EDGE_PIO_DEBOUNCE_EN to add a per-bit debounce filter with a DEB_PERIOD register.
module embed_edge_pio #(
    parameter int          WIDTH     = 10,
    parameter logic [15:0] DEB_RESET = 16'd1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1, s2, f, p;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap;
    logic [WIDTH-1:0] rise, fall, clr, wval;
    logic             wr;
    logic [31:0]      rmux;
    logic             unused_ok;

    assign wr        = chipselect & ~write_n;
    assign wval      = writedata[WIDTH-1:0];
    assign clr       = (wr && address == 3'd3) ? wval : '0;
    assign rise      = f & ~p & rise_en;
    assign fall      = ~f & p & fall_en;
    assign irq       = |(edge_cap & irq_mask);
    assign unused_ok = ^{writedata, DEB_RESET};

`ifdef EMBED_EDGE_PIO_DEBOUNCE_EN
    logic [15:0] deb_period;
    logic [15:0] cnt [WIDTH];

    // f only follows s2 once s2 has disagreed for DEB_PERIOD+1 cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            f          <= '0;
            deb_period <= DEB_RESET;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            if (wr && address == 3'd5) deb_period <= writedata[15:0];
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= deb_period) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    assign f = s2;
`endif

    always_comb begin
        rmux = '0;
        case (address)
            3'd0: rmux[WIDTH-1:0] = f;
            3'd1: rmux[WIDTH-1:0] = rise_en;
            3'd2: rmux[WIDTH-1:0] = irq_mask;
            3'd3: rmux[WIDTH-1:0] = edge_cap;
            3'd4: rmux[WIDTH-1:0] = fall_en;
`ifdef EMBED_EDGE_PIO_DEBOUNCE_EN
            3'd5: rmux[15:0]      = deb_period;
`endif
            default: rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            p        <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            s1       <= in_port;
            s2       <= s1;
            p        <= f;
            // a new edge overrides a same-cycle clear of that bit
            edge_cap <= (edge_cap & ~clr) | rise | fall;
            readdata <= rmux;
            if (wr) begin
                case (address)
                    3'd1:    rise_en  <= wval;
                    3'd2:    irq_mask <= wval;
                    3'd4:    fall_en  <= wval;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_embed_edge_pio.sv
// Testbench for embed_edge_pio: directed scenarios plus randomized traffic
// checked against a history-queue reference model.
module tb_embed_edge_pio;

    localparam int W = 10;
`ifdef EMBED_EDGE_PIO_DEBOUNCE_EN
    localparam int D   = 2;
    localparam bit DEB = 1'b1;
`else
    localparam int D   = 1;
    localparam bit DEB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    embed_edge_pio #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // Model: hist[i] = input applied i+1 edges ago; f is that input D edges later
    logic [W-1:0] hist[$];
    logic [W-1:0] m_ren, m_fen, m_msk, m_cap;
    logic [15:0]  m_dp;
    logic [31:0]  m_rd;

    task automatic cyc(input logic rs, input logic cs, input logic w,
                       input logic [2:0] a, input logic [31:0] wd,
                       input logic [W-1:0] v);
        logic [W-1:0] fv, pv, ed, cl;
        logic [31:0]  rd;
        reset = rs; chipselect = cs; write_n = ~w;
        address = a; writedata = wd; in_port = v;
        @(posedge clk);
        fv = hist[D];
        pv = hist[D+1];
        rd = '0;
        case (a)
            3'd0: rd[W-1:0] = fv;
            3'd1: rd[W-1:0] = m_ren;
            3'd2: rd[W-1:0] = m_msk;
            3'd3: rd[W-1:0] = m_cap;
            3'd4: rd[W-1:0] = m_fen;
            3'd5: if (DEB) rd[15:0] = m_dp;
            default: ;
        endcase
        ed = (fv & ~pv & m_ren) | (~fv & pv & m_fen);
        cl = (cs && w && a == 3'd3) ? wd[W-1:0] : '0;
        if (rs) begin
            m_ren = '0; m_fen = '0; m_msk = '0; m_cap = '0;
            m_dp = 16'd1000; m_rd = '0;
            hist.delete();
            repeat (D + 2) hist.push_back('0);
        end else begin
            m_cap = (m_cap & ~cl) | ed;
            if (cs && w) begin
                case (a)
                    3'd1: m_ren = wd[W-1:0];
                    3'd2: m_msk = wd[W-1:0];
                    3'd4: m_fen = wd[W-1:0];
                    3'd5: if (DEB) m_dp = wd[15:0];
                    default: ;
                endcase
            end
            m_rd = rd;
            hist.push_front(v);
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic idle(input logic [W-1:0] v);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, v);
    endtask

    task automatic rdreg(input logic [2:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, 32'd0, in_port);
    endtask

    task automatic wrreg(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, a, d, in_port);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, '0);
        if (DEB) wrreg(3'd5, 32'd0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, '1);
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_readdata: got %0h want 0", readdata);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        idle('0);
        rdreg(3'd1);
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_rise_en: got %0h want 0", readdata);
        end
        rdreg(3'd5);
        n_cmp++;
        if (readdata !== (DEB ? 32'd1000 : 32'd0)) begin
            n_bad++; $display("FAIL reset_deb_period: got %0d want %0d",
                              readdata, DEB ? 1000 : 0);
        end
        if (DEB) wrreg(3'd5, 32'd0);
    endtask

    task automatic test_latency();
        wrreg(3'd1, 32'h3FF);
        wrreg(3'd2, 32'h001);
        repeat (4) idle('0);
        wrreg(3'd3, 32'h3FF);
        for (int k = 1; k <= 4; k++) begin
            idle(10'h001);
            n_cmp++;
            if (irq !== (k >= D + 2)) begin
                n_bad++; $display("FAIL latency_irq_edge%0d: got %b want %b",
                                  k, irq, k >= D + 2);
            end
        end
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h001) begin
            n_bad++; $display("FAIL latency_cap: got %0h want 1", readdata);
        end
    endtask

    task automatic test_edge_sel();
        wrreg(3'd1, 32'h0);
        wrreg(3'd4, 32'h004);
        repeat (4) idle('0);
        wrreg(3'd3, 32'h3FF);
        repeat (3) idle(10'h004);
        repeat (5) idle('0);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h004) begin
            n_bad++; $display("FAIL edge_sel_fall: got %0h want 4", readdata);
        end
        wrreg(3'd4, 32'h0);
        wrreg(3'd3, 32'h3FF);
        repeat (3) idle(10'h004);
        repeat (5) idle('0);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL edge_sel_none: got %0h want 0", readdata);
        end
    endtask

    task automatic test_w1c();
        wrreg(3'd1, 32'h006);
        repeat (4) idle('0);
        wrreg(3'd3, 32'h3FF);
        repeat (3) idle(10'h006);
        repeat (4) idle('0);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h006) begin
            n_bad++; $display("FAIL w1c_set: got %0h want 6", readdata);
        end
        wrreg(3'd3, 32'h002);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h004) begin
            n_bad++; $display("FAIL w1c_clear: got %0h want 4", readdata);
        end
        // rise on bit2 reaches the capture stage D+1 edges after it is applied
        idle(10'h004);
        repeat (D) idle(10'h004);
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 32'h004, 10'h004);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h004) begin
            n_bad++; $display("FAIL w1c_collision: got %0h want 4", readdata);
        end
        wrreg(3'd3, 32'h004);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL w1c_plain_clear: got %0h want 0", readdata);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [2:0]   a;
            logic         w;
            logic [31:0]  d;
            logic [W-1:0] v;
            v = (($urandom % 4) == 0) ? W'($urandom) : in_port;
            a = 3'($urandom_range(0, 7));
            w = (($urandom % 3) == 0) && (a != 3'd5);
            d = $urandom;
            cyc(1'b0, ($urandom % 4) != 0, w, a, d, v);
            n_cmp++;
            if (readdata !== m_rd) begin
                n_bad++; $display("FAIL random_read[%0d]: got %0h want %0h",
                                  k, readdata, m_rd);
            end
            n_cmp++;
            if (irq !== |(m_cap & m_msk)) begin
                n_bad++; $display("FAIL random_irq[%0d]: got %b want %b",
                                  k, irq, |(m_cap & m_msk));
            end
        end
    endtask

    task automatic test_reset_mid();
        wrreg(3'd1, 32'h3FF);
        wrreg(3'd2, 32'h3FF);
        repeat (4) idle('0);
        repeat (4) idle(10'h3FF);
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h3FF || irq !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre: got cap %0h irq %b want 3ff 1",
                              readdata, irq);
        end
        cyc(1'b1, 1'b1, 1'b1, 3'd2, 32'h3FF, 10'h3FF);
        n_cmp++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset: got irq %b rd %0h want 0 0",
                              irq, readdata);
        end
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL mid_cap: got %0h want 0", readdata);
        end
        rdreg(3'd5);
        n_cmp++;
        if (readdata !== (DEB ? 32'd1000 : 32'd0)) begin
            n_bad++; $display("FAIL mid_deb_period: got %0d want %0d",
                              readdata, DEB ? 1000 : 0);
        end
        if (DEB) wrreg(3'd5, 32'd0);
    endtask

    task automatic test_reserved();
        wrreg(3'd1, 32'h155);
        wrreg(3'd2, 32'h0AA);
        wrreg(3'd4, 32'h033);
        wrreg(3'd6, 32'hFFFF_FFFF);
        wrreg(3'd7, 32'hFFFF_FFFF);
        rdreg(3'd6);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL resv_6: got %0h want 0", readdata);
        end
        rdreg(3'd7);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL resv_7: got %0h want 0", readdata);
        end
        rdreg(3'd1);
        n_cmp++;
        if (readdata !== 32'h155) begin
            n_bad++; $display("FAIL resv_rise_en: got %0h want 155", readdata);
        end
        rdreg(3'd2);
        n_cmp++;
        if (readdata !== 32'h0AA) begin
            n_bad++; $display("FAIL resv_mask: got %0h want 0aa", readdata);
        end
        rdreg(3'd4);
        n_cmp++;
        if (readdata !== 32'h033) begin
            n_bad++; $display("FAIL resv_fall_en: got %0h want 033", readdata);
        end
    endtask

`ifdef EMBED_EDGE_PIO_DEBOUNCE_EN
    task automatic test_debounce();
        int first;
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, '0);
        wrreg(3'd5, 32'd3);
        wrreg(3'd1, 32'h001);
        repeat (5) idle('0);
        repeat (3) idle(10'h001);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, '0);
            n_cmp++;
            if (readdata[0] !== 1'b0) begin
                n_bad++; $display("FAIL deb_glitch_f[%0d]: got %b want 0",
                                  k, readdata[0]);
            end
        end
        rdreg(3'd3);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL deb_glitch_cap: got %0h want 0", readdata);
        end
        first = -1;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, (k < 10) ? 10'h001 : 10'h000);
            if (readdata[0] === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first != 6) begin
            n_bad++; $display("FAIL deb_pulse_delay: got %0d want 6", first);
        end
        rdreg(3'd3);
        n_cmp++;
        if (readdata[0] !== 1'b1) begin
            n_bad++; $display("FAIL deb_pulse_cap: got %0h want bit0 set", readdata);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; in_port = '0;
        m_ren = '0; m_fen = '0; m_msk = '0; m_cap = '0;
        m_dp = 16'd1000; m_rd = '0;
        repeat (D + 2) hist.push_back('0);
        #1;
        test_reset();
        test_latency();
        test_edge_sel();
        test_w1c();
        do_reset();
        test_random();
        test_reset_mid();
        test_reserved();
`ifdef EMBED_EDGE_PIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
